// File: rtl/nn_bit_mem_pkg.sv
// Shared definitions for the bit-serial NN memory slice: controller states,
// bank count and default geometry.
package nn_bit_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_BANKS      = 4;
  localparam int DEF_W_ADDR_LEN = 20;
  localparam int DEF_X_ADDR_LEN = 10;
  localparam int DEF_W_DEPTH    = 16;
  localparam int DEF_X_DEPTH    = 4;
  localparam int DEF_SEL_LEN    = 2;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nn_bit_bank.sv
// One-bit-wide storage bank with a single write port and two registered read
// ports; addresses at or beyond DEPTH are dropped on write and read back as 0.
module nn_bit_bank
  import nn_bit_mem_pkg::*;
#(
  parameter int ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int DEPTH    = DEF_W_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic                wdata,
  input  logic [ADDR_LEN-1:0] raddr_a,
  output logic                rdata_a,
  input  logic [ADDR_LEN-1:0] raddr_b,
  output logic                rdata_b
);

  localparam int IDX_W = idx_width(DEPTH);
  // One extra bit so a depth equal to 2**ADDR_LEN still compares correctly.
  localparam logic [ADDR_LEN:0] DEPTH_L = (ADDR_LEN+1)'(DEPTH);

  logic mem [DEPTH];
  logic w_ok, a_ok, b_ok;

  assign w_ok = ({1'b0, waddr}   < DEPTH_L);
  assign a_ok = ({1'b0, raddr_a} < DEPTH_L);
  assign b_ok = ({1'b0, raddr_b} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= 1'b0;
      rdata_b <= 1'b0;
    end else begin
      rdata_a <= a_ok ? mem[raddr_a[IDX_W-1:0]] : 1'b0;
      rdata_b <= b_ok ? mem[raddr_b[IDX_W-1:0]] : 1'b0;
    end
  end

endmodule

// File: rtl/nn_bit_mem.sv
// Weight/activation bit memories with a host load port, an IDLE/RUN/DONE
// inference controller and a compute-side read/write port.
module nn_bit_mem
  import nn_bit_mem_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int W_DEPTH    = DEF_W_DEPTH,
  parameter int X_DEPTH    = DEF_X_DEPTH,
  parameter int SEL_LEN    = DEF_SEL_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_is_w,
  input  logic [SEL_LEN-1:0]    ld_sel,
  input  logic [W_ADDR_LEN-1:0] ld_addr,
  input  logic                  ld_data,
  input  logic                  start,
  output logic                  en,
  input  logic                  compute_finish,
  output logic                  done,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [SEL_LEN-1:0]    w_sel,
  output logic                  w_data,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [SEL_LEN-1:0]    x_sel,
  input  logic                  x_wq,
  input  logic                  wx_write,
  output logic                  x_data,
  input  logic [X_ADDR_LEN-1:0] rb_addr,
  output logic                  rb_data
);

  // Activation banks are addressed by both the wide load port and the narrow
  // compute port, so they use the wider of the two to avoid truncation.
  localparam int XB_LEN = (W_ADDR_LEN > X_ADDR_LEN) ? W_ADDR_LEN : X_ADDR_LEN;

  state_t               state;
  logic                 run;
  logic                 ld_fire;
  logic [NUM_BANKS-1:0] w_we, x_we;
  logic [NUM_BANKS-1:0] w_rd, x_rd, w_rb, x_rb;
  logic [XB_LEN-1:0]    x_waddr, x_raddr, x_rbaddr;
  logic                 x_wdata;
  logic [SEL_LEN-1:0]   w_sel_q, x_sel_q;
  logic                 unused_rb;

  assign run      = (state == ST_RUN);
  assign ld_fire  = rst_n && ld_valid && (state == ST_IDLE);
  assign x_waddr  = run ? XB_LEN'(x_addr) : XB_LEN'(ld_addr);
  assign x_wdata  = run ? wx_write : ld_data;
  assign x_raddr  = XB_LEN'(x_addr);
  assign x_rbaddr = XB_LEN'(rb_addr);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_we[b] = ld_fire && ld_is_w && (ld_sel == SEL_LEN'(b));
    assign x_we[b] = run ? (rst_n && x_wq && (x_sel == SEL_LEN'(b)))
                         : (ld_fire && !ld_is_w && (ld_sel == SEL_LEN'(b)));

    nn_bit_bank #(.ADDR_LEN(W_ADDR_LEN), .DEPTH(W_DEPTH)) u_w_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (w_we[b]),
      .waddr   (ld_addr),
      .wdata   (ld_data),
      .raddr_a (w_addr),
      .rdata_a (w_rd[b]),
      .raddr_b ('0),
      .rdata_b (w_rb[b])
    );

    nn_bit_bank #(.ADDR_LEN(XB_LEN), .DEPTH(X_DEPTH)) u_x_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (x_we[b]),
      .waddr   (x_waddr),
      .wdata   (x_wdata),
      .raddr_a (x_raddr),
      .rdata_a (x_rd[b]),
      .raddr_b (x_rbaddr),
      .rdata_b (x_rb[b])
    );
  end

  // Bank select is registered alongside the bank read so data and mux agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sel_q <= '0;
      x_sel_q <= '0;
    end else begin
      w_sel_q <= w_sel;
      x_sel_q <= x_sel;
    end
  end

  assign w_data    = w_rd[w_sel_q];
  assign x_data    = x_rd[x_sel_q];
  assign rb_data   = x_rb[NUM_BANKS-1];
  assign unused_rb = ^{w_rb, x_rb[NUM_BANKS-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      done     <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            en       <= 1'b1;
            done     <= 1'b0;
            ld_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (compute_finish) begin
            state <= ST_DONE;
            en    <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            en    <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          en       <= 1'b0;
          done     <= 1'b0;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
